// File: rtl/mc_path_gen.sv
// ---------------------------------------------------------------------------
// mc_path_gen
//   Monte-Carlo stock-path generator that feeds the option-pricing core.
//   Emits N paths of DAY daily prices each, one 12-bit price per valid/ready
//   handshake, in path-major order. Each step applies a discretised GBM
//   update S += S*(mu + sigma*z), where z is an approximate Gaussian formed
//   from the sum of the four bytes of a 32-bit Galois LFSR.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-high reset
//   start      in   run request, only honoured in IDLE
//   s0         in   initial price (unsigned, 12 bit), latched on start
//   mu         in   drift per step (signed, scale 2^-10), latched on start
//   sigma      in   volatility per step (unsigned), latched on start
//   out_valid  out  out_path/out_day/out_idx/out_last are valid
//   out_ready  in   consumer accepts the current sample
//   out_path   out  price sample (unsigned, 12 bit)
//   out_day    out  day index of the sample, 0..DAY-1
//   out_idx    out  path index of the sample, 0..N-1
//   out_last   out  marks the final sample of the run
//   done       out  one-cycle pulse after the final handshake
// ---------------------------------------------------------------------------
module mc_path_gen #(
  parameter int          N    = 256,
  parameter int          DAY  = 8,
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [11:0]              s0,
  input  logic [7:0]               mu,
  input  logic [7:0]               sigma,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [11:0]              out_path,
  output logic [$clog2(DAY)-1:0]   out_day,
  output logic [$clog2(N)-1:0]     out_idx,
  output logic                     out_last,
  output logic                     done
);

  localparam int          PW        = $clog2(N);
  localparam int          DW        = $clog2(DAY);
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [31:0] LFSR_INIT = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Run parameters latched on start
  logic [11:0]   r_s0;
  logic [7:0]    r_mu;
  logic [7:0]    r_sigma;

  // Generator state
  logic [11:0]   r_s;
  logic [PW-1:0] r_p;
  logic [DW-1:0] r_d;
  logic [31:0]   r_lfsr;

  // Output registers
  logic          r_valid;
  logic [11:0]   r_path;
  logic [DW-1:0] r_day;
  logic [PW-1:0] r_idx;
  logic          r_last;
  logic          r_done;

  // FSM control strobes
  logic w_accept;   // latch a new run
  logic w_compute;  // compute the next sample into the output registers
  logic w_finish;   // final sample consumed

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_compute    = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // The cycle carrying the done pulse is the IDLE-entry cycle; a start
        // seen there is deliberately dropped.
        if (start && !r_done) begin
          w_accept     = 1'b1;
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_compute    = 1'b1;
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (r_valid && out_ready) begin
          if (r_last) begin
            w_finish     = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_compute = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sample arithmetic
  // -------------------------------------------------------------------------
  logic [11:0]        w_s_base;
  logic [9:0]         w_bsum;
  logic signed [10:0] w_z;
  logic signed [19:0] w_sig_ext;
  logic signed [19:0] w_z_ext;
  logic signed [19:0] w_prod1;
  logic signed [11:0] w_inc;
  logic signed [11:0] w_r;
  logic signed [24:0] w_s_ext;
  logic signed [24:0] w_r_ext;
  logic signed [24:0] w_prod2;
  logic signed [15:0] w_delta;
  logic signed [15:0] w_snew;
  logic [11:0]        w_sat;
  logic [31:0]        w_lfsr_next;
  logic               w_day_end;
  logic               w_last_sample;

  // In LOAD the running price has not been seeded yet, so use s0 directly.
  assign w_s_base = (r_state == ST_LOAD) ? r_s0 : r_s;

  // Sum of four uniform bytes, centred: a cheap bell-shaped z in +/-510.
  assign w_bsum = {2'b00, r_lfsr[7:0]}   + {2'b00, r_lfsr[15:8]} +
                  {2'b00, r_lfsr[23:16]} + {2'b00, r_lfsr[31:24]};
  assign w_z    = $signed({1'b0, w_bsum}) - 11'sd510;

  // Operands are widened explicitly so the products cannot overflow.
  assign w_sig_ext = $signed({12'b0, r_sigma});
  assign w_z_ext   = {{9{w_z[10]}}, w_z};
  assign w_prod1   = w_sig_ext * w_z_ext;
  assign w_inc     = 12'(w_prod1 >>> 8);
  assign w_r       = w_inc + $signed({{4{r_mu[7]}}, r_mu});

  assign w_s_ext   = $signed({13'b0, w_s_base});
  assign w_r_ext   = {{13{w_r[11]}}, w_r};
  assign w_prod2   = w_s_ext * w_r_ext;
  assign w_delta   = 16'(w_prod2 >>> 10);
  assign w_snew    = $signed({4'b0, w_s_base}) + w_delta;

  always_comb begin
    w_sat = w_snew[11:0];
    if (w_snew[15]) begin
      w_sat = 12'd0;
    end else if (w_snew > 16'sd4095) begin
      w_sat = 12'hFFF;
    end
  end

  assign w_lfsr_next   = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_MASK : 32'h0);
  assign w_day_end     = (r_d == DW'(DAY - 1));
  assign w_last_sample = (r_p == PW'(N - 1)) && w_day_end;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0    <= '0;
      r_mu    <= '0;
      r_sigma <= '0;
      r_s     <= '0;
      r_p     <= '0;
      r_d     <= '0;
      r_lfsr  <= LFSR_INIT;
      r_valid <= 1'b0;
      r_path  <= '0;
      r_day   <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_finish;

      if (w_accept) begin
        r_s0    <= s0;
        r_mu    <= mu;
        r_sigma <= sigma;
        r_p     <= '0;
        r_d     <= '0;
      end

      if (w_compute) begin
        r_path  <= w_sat;
        r_day   <= r_d;
        r_idx   <= r_p;
        r_last  <= w_last_sample;
        r_valid <= 1'b1;
        r_lfsr  <= w_lfsr_next;
        if (w_day_end) begin
          // Path complete: next path restarts from the initial price.
          r_d <= '0;
          r_p <= r_p + PW'(1);
          r_s <= r_s0;
        end else begin
          r_d <= r_d + DW'(1);
          r_s <= w_sat;
        end
      end

      if (w_finish) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_path  = r_path;
  assign out_day   = r_day;
  assign out_idx   = r_idx;
  assign out_last  = r_last;
  assign done      = r_done;

endmodule

// File: tb/tb_mc_path_gen.sv
// ---------------------------------------------------------------------------
// tb_mc_path_gen
//   Self-checking bench for mc_path_gen. A behavioural model computes each
//   expected price directly from the GBM step rules and a software LFSR;
//   the DUT stream is compared sample by sample under constant, stalled and
//   random backpressure, around resets and across back-to-back runs.
// ---------------------------------------------------------------------------
module tb_mc_path_gen;

  localparam int          N     = 256;
  localparam int          DAY   = 8;
  localparam int          TOTAL = N * DAY;
  localparam logic [31:0] SEED  = 32'hACE1_2468;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] s0 = '0;
  logic [7:0]  mu = '0;
  logic [7:0]  sigma = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_path;
  logic [2:0]  out_day;
  logic [7:0]  out_idx;
  logic        out_last;
  logic        done;

  int          n_checks = 0;
  int          n_fail   = 0;

  logic [31:0] m_lfsr;
  int          exp_path [TOTAL];
  int          cap      [TOTAL];
  int          cap_a    [TOTAL];

  mc_path_gen #(
    .N   (N),
    .DAY (DAY),
    .SEED(SEED)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .s0       (s0),
    .mu       (mu),
    .sigma    (sigma),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_path (out_path),
    .out_day  (out_day),
    .out_idx  (out_idx),
    .out_last (out_last),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Reference: the whole run's price list from the GBM rules in integers.
  task automatic gen_expected(input int s0_v, input int mu_v, input int sigma_v);
    int s, z, inc, r, delta;
    s = s0_v;
    for (int k = 0; k < TOTAL; k++) begin
      if (k % DAY == 0) s = s0_v;
      z = int'(m_lfsr[7:0]) + int'(m_lfsr[15:8]) +
          int'(m_lfsr[23:16]) + int'(m_lfsr[31:24]) - 510;
      inc   = (sigma_v * z) >>> 8;
      r     = mu_v + inc;
      delta = (s * r) >>> 10;
      s     = s + delta;
      if (s < 0) s = 0;
      if (s > 4095) s = 4095;
      exp_path[k] = s;
      m_lfsr = lfsr_step(m_lfsr);
    end
  endtask

  // One run: start, consume samples, compare against the model.
  task automatic run_stream(input string name, input int s0_v, input int mu_v,
                            input int sigma_v, input bit rand_ready,
                            input int stall_at, input int abort_at,
                            input int pulse_at, input bit start_on_done);
    int          k, cyc, stall;
    bit          held, pulsed;
    logic [11:0] h_path;
    logic [2:0]  h_day;
    logic [7:0]  h_idx;
    logic        h_last;
    gen_expected(s0_v, mu_v, sigma_v);
    @(negedge clk);
    s0 = 12'(s0_v); mu = 8'(mu_v); sigma = 8'(sigma_v);
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs: the run must use the values latched at start.
    s0 = 12'($urandom); mu = 8'($urandom); sigma = 8'($urandom);
    check({name, "_lat1_valid"}, 32'(out_valid), 0);
    @(negedge clk);
    check({name, "_lat2_valid"}, 32'(out_valid), 1);
    k = 0; cyc = 0; stall = 0; held = 0; pulsed = 0;
    h_path = '0; h_day = '0; h_idx = '0; h_last = 1'b0;
    while (k < TOTAL && cyc < 20000) begin
      if (held) begin
        check({name, "_hold_path"}, 32'(out_path), 32'(h_path));
        check({name, "_hold_day"},  32'(out_day),  32'(h_day));
        check({name, "_hold_idx"},  32'(out_idx),  32'(h_idx));
        check({name, "_hold_last"}, 32'(out_last), 32'(h_last));
      end
      if (done) check({name, "_done_early"}, 32'(done), 0);
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      else if (k == stall_at && stall < 5) begin out_ready = 1'b0; stall++; end
      else out_ready = 1'b1;
      start = (k == pulse_at) && !pulsed;
      if (start) pulsed = 1'b1;
      if (k == abort_at) break;
      if (out_valid && out_ready) begin
        check({name, "_path"}, 32'(out_path), 32'(exp_path[k]));
        check({name, "_day"},  32'(out_day),  32'(k % DAY));
        check({name, "_idx"},  32'(out_idx),  32'(k / DAY));
        check({name, "_last"}, 32'(out_last), 32'(k == TOTAL - 1));
        cap[k] = int'(out_path);
        k++;
        held = 1'b0;
      end else begin
        held   = out_valid;
        h_path = out_path; h_day = out_day; h_idx = out_idx; h_last = out_last;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (abort_at >= 0 && k == abort_at) return;
    if (k < TOTAL) check({name, "_timeout"}, 32'(k), 32'(TOTAL));
    check({name, "_done_pulse"}, 32'(done), 1);
    check({name, "_end_valid"},  32'(out_valid), 0);
    check({name, "_end_last"},   32'(out_last), 0);
    if (start_on_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_done_once"}, 32'(done), 0);
    if (start_on_done) begin
      repeat (3) begin
        @(negedge clk);
        check({name, "_start_on_done_ignored"}, 32'(out_valid), 0);
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int diff;
    m_lfsr = SEED;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_last",  32'(out_last), 0);
    check("rst_done",  32'(done), 0);
    check("rst_path",  32'(out_path), 0);
    check("rst_day",   32'(out_day), 0);
    check("rst_idx",   32'(out_idx), 0);
    rst = 1'b0;

    // Scenario 4: sigma=64 from the reset seed, 5-cycle stall mid-path.
    run_stream("s4", 2048, 0, 64, 1'b0, 700, -1, -1, 1'b0);

    // Scenario 5: reset at sample 100, then restart from the reset seed.
    m_lfsr = SEED;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_stream("s5a", 2048, 0, 64, 1'b1, -1, 100, -1, 1'b0);
    rst = 1'b1;
    #1;
    check("s5_rst_valid", 32'(out_valid), 0);
    check("s5_rst_path",  32'(out_path), 0);
    check("s5_rst_idx",   32'(out_idx), 0);
    check("s5_rst_last",  32'(out_last), 0);
    repeat (3) begin
      @(negedge clk);
      check("s5_rst_no_done", 32'(done), 0);
    end
    rst = 1'b0;
    m_lfsr = SEED;
    repeat (3) begin
      @(negedge clk);
      check("s5_idle_no_valid", 32'(out_valid), 0);
    end
    run_stream("s5b", 2048, 0, 64, 1'b1, -1, -1, -1, 1'b0);

    // Scenario 1: flat price.
    run_stream("s1", 2048, 0, 0, 1'b0, -1, -1, -1, 1'b0);

    // Scenario 2: deterministic drift, every path restarts at s0.
    run_stream("s2", 1024, 16, 0, 1'b1, -1, -1, -1, 1'b0);
    check("s2_d0", 32'(cap[0]), 1040);
    check("s2_d1", 32'(cap[1]), 1056);
    check("s2_d2", 32'(cap[2]), 1072);
    check("s2_d3", 32'(cap[3]), 1088);
    check("s2_p1_d0", 32'(cap[8]), 1040);

    // Scenario 3: saturation at both ends; start during done is dropped.
    run_stream("s3a", 4000, 127, 0, 1'b0, -1, -1, -1, 1'b0);
    check("s3a_d0", 32'(cap[0]), 4095);
    check("s3a_d7", 32'(cap[7]), 4095);
    run_stream("s3b", 100, -128, 0, 1'b1, -1, -1, -1, 1'b1);

    // Scenario 6: mid-run start pulse ignored; next run continues the LFSR.
    run_stream("s6a", 1500, 5, 64, 1'b0, -1, -1, 300, 1'b0);
    for (int i = 0; i < TOTAL; i++) cap_a[i] = cap[i];
    run_stream("s6b", 1500, 5, 64, 1'b1, -1, -1, -1, 1'b0);
    diff = 0;
    for (int i = 0; i < TOTAL; i++) if (cap[i] != cap_a[i]) diff++;
    check("s6_runs_differ", 32'(diff != 0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
